// File: rtl/prbs_pkg.sv
// Shared PRBS-7 definitions: polynomial x^7+x^6+1 taps, register length and checker states.
package prbs_pkg;
    localparam int PRBS7_TAP_HI = 6;
    localparam int PRBS7_TAP_LO = 5;
    localparam int PRBS7_LEN    = 7;

    typedef enum logic [1:0] {
        FILL,
        SEARCH,
        LOCKED
    } state_t;
endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module prbs_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end
endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS-7 receive checker: fills, searches for LOCK_COUNT matches,
// then free-runs its reference and counts bits/errors until too many errors in a window.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW      = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int FC_W = $clog2(PRBS7_LEN + 1);
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int WB_W = $clog2(WINDOW + 1);
    localparam int WE_W = $clog2(UNLOCK_ERRS + 1);

    state_t               state, state_nx;
    logic [PRBS7_LEN-1:0] ref_r, ref_nx;
    logic [FC_W-1:0]      fill_cnt, fill_nx;
    logic [MC_W-1:0]      match_cnt, match_nx;
    logic [WB_W-1:0]      win_bits, wb_nx;
    logic [WE_W-1:0]      win_errs, we_nx;
    logic                 pulse_nx;
    logic                 inc_bits, inc_errs;
    logic                 predicted, match;

    assign predicted = ref_r[PRBS7_TAP_HI] ^ ref_r[PRBS7_TAP_LO];
    // An all-zero reference is the LFSR lock-up state, so it never counts as a match.
    assign match     = (bit_in == predicted) && (ref_r != '0);

    always_comb begin
        state_nx = state;
        ref_nx   = ref_r;
        fill_nx  = fill_cnt;
        match_nx = match_cnt;
        wb_nx    = win_bits;
        we_nx    = win_errs;
        pulse_nx = 1'b0;
        inc_bits = 1'b0;
        inc_errs = 1'b0;
        if (bit_valid) begin
            case (state)
                FILL: begin
                    ref_nx = {ref_r[PRBS7_LEN-2:0], bit_in};
                    if (fill_cnt == FC_W'(PRBS7_LEN - 1)) begin
                        state_nx = SEARCH;
                        fill_nx  = '0;
                    end else begin
                        fill_nx = fill_cnt + 1'b1;
                    end
                end
                SEARCH: begin
                    ref_nx = {ref_r[PRBS7_LEN-2:0], bit_in};
                    if (!match) begin
                        match_nx = '0;
                    end else if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                        state_nx = LOCKED;
                        match_nx = '0;
                        wb_nx    = '0;
                        we_nx    = '0;
                    end else begin
                        match_nx = match_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    // Free-running reference: a channel error is not fed back into the predictor.
                    ref_nx   = {ref_r[PRBS7_LEN-2:0], predicted};
                    pulse_nx = !match;
                    inc_bits = 1'b1;
                    inc_errs = !match;
                    if (!match && (win_errs == WE_W'(UNLOCK_ERRS - 1))) begin
                        state_nx = FILL;
                        fill_nx  = '0;
                        match_nx = '0;
                    end else if (win_bits == WB_W'(WINDOW - 1)) begin
                        wb_nx = '0;
                        we_nx = '0;
                    end else begin
                        wb_nx = win_bits + 1'b1;
                        we_nx = win_errs + WE_W'(!match);
                    end
                end
                default: state_nx = FILL;
            endcase
        end
        if (clear) begin
            wb_nx = '0;
            we_nx = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            ref_r     <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            ref_r     <= ref_nx;
            fill_cnt  <= fill_nx;
            match_cnt <= match_nx;
            win_bits  <= wb_nx;
            win_errs  <= we_nx;
            err_pulse <= pulse_nx;
        end
    end

    assign locked = (state == LOCKED);

    prbs_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (inc_bits),
        .clr   (clear),
        .q     (bit_count)
    );

    prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (inc_errs),
        .clr   (clear),
        .q     (err_count)
    );
endmodule

// File: tb/tb_prbs7_checker.sv
// Self-checking bench for prbs7_checker: a 32-bit and a 4-bit counter instance share
// stimulus and are compared every cycle against a queue-based behavioural model.
module tb_prbs7_checker;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clear = 1'b0;
    logic        locked, err_pulse;
    logic [31:0] bit_count, err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  bit_count4, err_count4;

    always #5 clock = ~clock;

    prbs7_checker u_dut (
        .clock (clock), .reset (reset), .bit_in (bit_in), .bit_valid (bit_valid),
        .clear (clear), .locked (locked), .err_pulse (err_pulse),
        .bit_count (bit_count), .err_count (err_count)
    );

    prbs7_checker #(.CNT_W(4)) u_dut4 (
        .clock (clock), .reset (reset), .bit_in (bit_in), .bit_valid (bit_valid),
        .clear (clear), .locked (locked4), .err_pulse (err_pulse4),
        .bit_count (bit_count4), .err_count (err_count4)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Behavioural model: history of the last 7 reference bits, oldest first.
    bit     m_hist[$];
    int     m_mode;   // 0 fill, 1 search, 2 locked
    int     m_fill, m_run, m_wb, m_we;
    longint m_bits, m_errs;
    bit     m_pulse;

    // Stimulus generator: last 7 sequence bits, oldest first.
    bit     g_q[$];

    function automatic longint sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_run = 0; m_wb = 0; m_we = 0;
        m_bits = 0; m_errs = 0; m_pulse = 0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic c);
        bit pred, hz, err;
        m_pulse = 0;
        if (v) begin
            pred = m_hist[0] ^ m_hist[1];
            hz = 1;
            foreach (m_hist[i]) if (m_hist[i]) hz = 0;
            err = (b != pred) || hz;
            m_hist.pop_front();
            m_hist.push_back((m_mode == 2) ? pred : b);
            if (m_mode == 0) begin
                m_fill++;
                if (m_fill == 7) begin m_mode = 1; m_fill = 0; end
            end else if (m_mode == 1) begin
                if (err) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == 16) begin m_mode = 2; m_run = 0; m_wb = 0; m_we = 0; end
                end
            end else begin
                m_pulse = err;
                m_bits++;
                m_errs += err;
                m_wb++;
                m_we += err;
                if (m_we == 8) begin m_mode = 0; m_fill = 0; m_run = 0; end
                else if (m_wb == 64) begin m_wb = 0; m_we = 0; end
            end
        end
        if (c) begin m_bits = 0; m_errs = 0; m_wb = 0; m_we = 0; end
    endtask

    task automatic check_all();
        chk("locked", 64'(locked), 64'(m_mode == 2));
        chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
        chk("bit_count", 64'(bit_count), sat(m_bits, 32));
        chk("err_count", 64'(err_count), sat(m_errs, 32));
        chk("locked4", 64'(locked4), 64'(m_mode == 2));
        chk("err_pulse4", 64'(err_pulse4), 64'(m_pulse));
        chk("bit_count4", 64'(bit_count4), sat(m_bits, 4));
        chk("err_count4", 64'(err_count4), sat(m_errs, 4));
    endtask

    task automatic gen_seed(input logic [6:0] seed);
        g_q = {};
        for (int i = 6; i >= 0; i--) g_q.push_back(seed[i]);
    endtask

    task automatic gen_next(output logic b);
        b = g_q[0];
        g_q.push_back(g_q[0] ^ g_q[1]);
        g_q.pop_front();
    endtask

    task automatic cyc(input logic b, input logic v, input logic c);
        bit_in = b; bit_valid = v; clear = c;
        @(posedge clock);
        if (reset) model_reset();
        else model_step(b, v, c);
        #1;
        check_all();
        if (err_pulse) pulses++;
    endtask

    task automatic clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin gen_next(b); cyc(b, 1'b1, 1'b0); end
    endtask

    task automatic flipped(input logic c);
        logic b;
        gen_next(b);
        cyc(~b, 1'b1, c);
    endtask

    initial begin
        logic b, v;
        int   nvalid, seen;
        model_reset();
        #3;
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_bit_count", 64'(bit_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_err_pulse", 64'(err_pulse), 64'd0);
        check_all();
        @(posedge clock); #1;
        reset = 1'b0;

        // Clean lock from reset: 7 fill + 16 matches.
        gen_seed(7'h0F);
        clean(22);
        chk("lock_before_23", 64'(locked), 64'd0);
        clean(1);
        chk("lock_at_23", 64'(locked), 64'd1);
        clean(20);
        chk("sat4_bit_count", 64'(bit_count4), 64'd15);
        chk("bit_count_20", 64'(bit_count), 64'd20);
        clean(980);
        chk("bit_count_1000", 64'(bit_count), 64'd1000);
        chk("err_count_clean", 64'(err_count), 64'd0);

        // Clear together with an errored bit.
        flipped(1'b1);
        chk("clr_bit_count", 64'(bit_count), 64'd0);
        chk("clr_err_count", 64'(err_count), 64'd0);
        chk("clr_err_pulse", 64'(err_pulse), 64'd1);
        chk("clr_bit_count4", 64'(bit_count4), 64'd0);
        chk("clr_err_pulse4", 64'(err_pulse4), 64'd1);

        // Single flipped bit while locked.
        pulses = 0;
        clean(10);
        flipped(1'b0);
        clean(10);
        chk("single_err_count", 64'(err_count), 64'd1);
        chk("single_pulses", 64'(pulses), 64'd1);
        chk("single_locked", 64'(locked), 64'd1);
        chk("single_bit_count", 64'(bit_count), 64'd21);

        // Eight errors inside one window drops lock.
        gen_next(b); cyc(b, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            clean(2);
            if (k == 7) chk("lock_before_8th", 64'(locked), 64'd1);
            flipped(1'b0);
        end
        chk("unlock_after_8th", 64'(locked), 64'd0);
        chk("unlock_err_count", 64'(err_count), 64'd8);
        chk("unlock_bit_count", 64'(bit_count), 64'd24);
        clean(22);
        chk("relock_before_23", 64'(locked), 64'd0);
        clean(1);
        chk("relock_at_23", 64'(locked), 64'd1);

        // Random gaps, injected errors and clears.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(3) != 0);
            b = $urandom_range(1);
            if (v) begin
                gen_next(b);
                if ($urandom_range(49) == 0) b = ~b;
            end
            cyc(b, v, ($urandom_range(199) == 0));
        end

        // Reset mid-lock with toggling valid.
        if (!locked) clean(40);
        chk("locked_before_reset", 64'(locked), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_locked", 64'(locked), 64'd0);
        chk("async_rst_bit_count", 64'(bit_count), 64'd0);
        chk("async_rst_err_count", 64'(err_count), 64'd0);
        model_reset();
        check_all();
        for (int i = 0; i < 3; i++) cyc($urandom_range(1), $urandom_range(1), 1'b0);
        reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 400 && !locked; i++) begin
            v = $urandom_range(1);
            b = $urandom_range(1);
            if (v) begin gen_next(b); nvalid++; end
            cyc(b, v, 1'b0);
        end
        chk("relock_gapped", 64'(locked), 64'd1);
        chk("relock_gapped_bits", 64'(nvalid), 64'd23);

        // All-zero stream never locks.
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (locked) seen = 1;
        end
        chk("zero_never_locked", 64'(seen), 64'd0);
        chk("zero_bit_count", 64'(bit_count), 64'd0);
        chk("zero_err_count", 64'(err_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Receive-side PRBS-7 checker for the BERT. It sits directly downstream of the PRBS-7 generator, or of the channel under test that the generator drives. It self-synchronises to an incoming serial x^7+x^6+1 stream, declares lock, and then counts received bits and bit errors in saturating counters for the BER readout.

## Interface
- LOCK_COUNT, 16: consecutive matching bits required, after the register fill, to declare lock.
- WINDOW, 64: length in valid bits of the lock-loss observation window.
- UNLOCK_ERRS, 8: number of errors within one window that drops lock.
- CNT_W, 32: width of bit_count and err_count.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is sampled only when this is high. Gaps are allowed.
- clear  in  1  synchronous clear of bit_count, err_count and the window counters. Lock state is unaffected.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per errored bit while locked.
- bit_count  out  CNT_W  valid bits checked while locked; saturates at all-ones.
- err_count  out  CNT_W  errored bits while locked; saturates at all-ones.

## Operation
- Reference register ref[6:0]:
  - predicted bit p = ref[6]^ref[5].
  - Each valid bit updates it as ref <= {ref[5:0], x}.
  - In FILL and SEARCH, x = bit_in (self-synchronising).
  - In LOCKED, x = p (free-running), so one channel error counts exactly once.
- Match condition: bit_in == p and ref != 0. An all-zero ref always counts as a mismatch, so an all-zero stream can never lock.
- FSM states FILL, SEARCH, LOCKED; reset state is FILL.
  - FILL: shifts in 7 valid bits, then goes to SEARCH. No comparison is made during FILL.
  - SEARCH: match_cnt increments on a match and is cleared on a mismatch. When match_cnt reaches LOCK_COUNT, go to LOCKED.
  - LOCKED: every valid bit increments bit_count. A mismatch increments err_count and win_errs and pulses err_pulse.
    - win_bits counts valid bits; when it reaches WINDOW, win_bits and win_errs reset to 0.
    - When win_errs reaches UNLOCK_ERRS, go to FILL and clear match_cnt. bit_count and err_count hold their values.
- On entry to LOCKED, win_bits and win_errs start at 0.
- Counting starts with the first valid bit after the LOCKED transition. The bit that completes LOCK_COUNT is not counted.
- clear has priority over counting. That cycle's bit and error are discarded, so both counters read 0 afterwards. err_pulse still reflects the bit.
- Saturation: a counter at all-ones stays at all-ones; the other counter continues.
- bit_valid low: no state changes and err_pulse is 0.

## Timing
- Reset values: locked=0, err_pulse=0, bit_count=0, err_count=0, ref=0, match_cnt=0, state FILL.
- All outputs are registered:
  - err_pulse and counter updates appear the cycle after the sampled bit (1-cycle latency).
  - locked rises the cycle after the LOCK_COUNT-th match.
- Minimum lock time from reset with clean back-to-back data: 7 + LOCK_COUNT valid bits, plus 1 cycle.
- Lock loss: locked falls the cycle after the bit that brings win_errs to UNLOCK_ERRS. That bit is still counted.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). Lock is reacquired from FILL.

## Structure
- Shared package prbs_pkg:
  - PRBS7_TAP_HI=6 and PRBS7_TAP_LO=5.
  - PRBS7_LEN=7.
  - state enum {FILL, SEARCH, LOCKED}.
- Sub-module prbs_sat_counter (CNT_W, inc, clr → q), instantiated twice, for bit_count and err_count.

## Test plan
- Generator output seeded 0x0F, back-to-back valid, LOCK_COUNT=16 → locked high after 23 valid bits + 1 cycle. After 1000 further bits, bit_count=1000 and err_count=0.
- Locked; flip a single bit in the stream → exactly one err_pulse, err_count=1, locked stays high.
- All-zero stream for 200 bits → locked never asserts, counters stay 0.
- Locked; flip 8 bits inside one 64-bit window → locked falls the cycle after the 8th error, err_count=8. Clean data then relocks after 23 more valid bits.
- CNT_W=4, locked, 20 clean bits → bit_count=15 (saturated). Assert clear together with an errored bit → both counters 0 next cycle and err_pulse=1.
- Assert reset mid-lock with bit_valid toggling randomly → locked=0 and counters=0 immediately; relock succeeds with gapped valid.
